cam_pixel_packer: RTL
=====================

CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO depth in 64-bit words; power of two, at least 4.
REQ-002 Parameter FRAME_BYTES, default 307200 (640x480), bytes per frame; multiple of 8.
REQ-003 pclk  in  1  sole clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 frame_start  in  1  one-cycle pulse marking a new frame, driven by the camera reader's vsync rising edge.
REQ-006 pixel_valid  in  1  the byte on pixel is valid this cycle; there is no back-pressure to upstream.
REQ-007 pixel  in  8  raw pixel byte.
REQ-008 out_valid  out  1  out_data and out_last hold a word.
REQ-009 out_ready  in  1  the consumer accepts the word; transfer occurs when out_valid and out_ready are both high.
REQ-010 out_data  out  64  packed word; the earliest byte is in bits [7:0].
REQ-011 out_last  out  1  the word is the final word of a frame.
REQ-012 drop_cnt  out  32  words dropped because the FIFO was full; saturates at 2^32-1.
REQ-013 resync_cnt  out  32  frames aborted by an early frame_start; saturates.
REQ-014 busy  out  1  the state is ACTIVE.

Function
REQ-015 The state machine has states IDLE and ACTIVE.
- IDLE -> ACTIVE on frame_start.
- ACTIVE -> IDLE on the cycle the FRAME_BYTES-th byte is accepted.
REQ-016 In IDLE, pixel_valid is ignored and no bytes are packed.
REQ-017 In ACTIVE, each cycle with pixel_valid high:
- the byte goes to lane byte_idx (3-bit counter, 0..7);
- byte_idx increments and wraps 7 -> 0;
- byte_cnt (19 bits minimum) increments.
REQ-018 When lane 7 is filled, the completed word is pushed into the FIFO that same cycle. out_last of the pushed word equals 1 only when byte_cnt reaches FRAME_BYTES.
REQ-019 The FIFO output is registered. A word pushed on cycle N gives out_valid=1 no earlier than cycle N+1.
REQ-020 If the FIFO is full on a push cycle, the word is discarded and drop_cnt increments. This holds even if a pop occurs the same cycle.
REQ-021 If the dropped word carried out_last, the frame still ends: the state returns to IDLE and no out_last is emitted for that frame.
REQ-022 out_data, out_valid and out_last stay stable while out_valid=1 and out_ready=0.
REQ-023 A push and a pop in the same cycle on a non-full, non-empty FIFO leave the occupancy unchanged.
REQ-024 frame_start in ACTIVE:
- the partial word is discarded;
- byte_idx and byte_cnt clear to 0;
- resync_cnt increments;
- the state stays ACTIVE for the new frame;
- FIFO contents are kept.
REQ-025 If frame_start and pixel_valid are high in the same cycle, that byte is lane 0 of the new frame.
REQ-026 frame_start on the cycle of the final byte: the final word is pushed with out_last=1, resync_cnt is not incremented, and the state stays ACTIVE with counters cleared.

Reset
REQ-027 With rst_n low, outputs are held asynchronously at:
- out_valid=0, out_last=0, out_data=0;
- drop_cnt=0, resync_cnt=0, busy=0.
REQ-028 With rst_n low, internal state is held at: state=IDLE, byte_idx=0, byte_cnt=0, FIFO empty.
REQ-029 Reset asserted mid-frame discards all buffered data. After release, the block waits for a fresh frame_start.

Structure
REQ-030 Shared package cam_pkg holds:
- PIX_PER_LINE=640, NUM_LINES=480;
- WORD_BYTES=8;
- the state enum {IDLE, ACTIVE}.
REQ-031 The FIFO is a single sub-module, cam_word_fifo, a synchronous 65-bit (data plus last) FIFO with full/empty flags. No other sub-modules exist.

Verification
REQ-032 frame_start, then 16 consecutive bytes 0x00..0x0F with out_ready=1 -> two words, 0x0706050403020100 then 0x0F0E0D0C0B0A0908, out_last=0.
REQ-033 FRAME_BYTES=64, a full frame with gapped pixel_valid and out_ready=1 -> 8 words, only the 8th has out_last=1, then busy=0.
REQ-034 out_ready=0, FIFO_DEPTH=16, 20 words pushed -> drop_cnt=4; draining the FIFO yields the first 16 words in order.
REQ-035 frame_start after 13 bytes -> resync_cnt=1 and 1 word output; the next 8 bytes form a word starting at lane 0.
REQ-036 rst_n pulsed low after 5 bytes with 2 words buffered -> out_valid=0 immediately; no output until a new frame_start and 8 bytes.
REQ-037 Pixels before the first frame_start are ignored -> no output.

Source files
------------

// File: rtl/cam_pkg.sv
// ============================================================================
// Module      : cam_pkg
// Description : Shared constants, state type and sizing helper for the
//               camera pixel packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    localparam int PIX_PER_LINE        = 640;
    localparam int NUM_LINES           = 480;
    localparam int WORD_BYTES          = 8;
    localparam int DEFAULT_FRAME_BYTES = PIX_PER_LINE * NUM_LINES;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } cam_state_e;

    // Byte counter must hold a full frame and never be narrower than 19 bits.
    function automatic int cnt_width(input int frame_bytes);
        int w;
        w = $clog2(frame_bytes + 1);
        return (w < 19) ? 19 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_word_fifo.sv
// ============================================================================
// Module      : cam_word_fifo
// Description : Synchronous word FIFO with full/empty flags; a push while
//               full is discarded even when a pop happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 65
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  C_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == C_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Head word is read straight from storage; empty forces zero so the
    // output is clean during and right after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge pclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cam_pixel_packer.sv
// ============================================================================
// Module      : cam_pixel_packer
// Description : Packs camera bytes into 64-bit words (earliest byte in the
//               low lane), tags the last word of each frame, buffers output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic [31:0] drop_cnt,
    output logic [31:0] resync_cnt,
    output logic        busy
);

    localparam int               CNT_W       = cnt_width(FRAME_BYTES);
    localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(FRAME_BYTES - 1);
    localparam logic [2:0]       C_LAST_LANE = 3'(WORD_BYTES - 1);

    cam_state_e       r_state;
    logic [2:0]       r_byte_idx;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [55:0]      r_lanes;
    logic [31:0]      r_drop_cnt;
    logic [31:0]      r_resync_cnt;

    logic        w_active;
    logic        w_final;
    logic        w_restart;
    logic        w_take;
    logic [2:0]  w_lane;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [64:0] w_rdata;

    assign w_active  = (r_state == ACTIVE);
    assign w_final   = w_active && pixel_valid && (r_byte_cnt == C_LAST_CNT);
    // A frame_start that coincides with the final byte closes the old frame
    // normally; only an early one restarts the packer.
    assign w_restart = frame_start && !w_final;
    assign w_take    = pixel_valid && (w_active || frame_start);
    assign w_lane    = w_restart ? 3'd0 : r_byte_idx;
    assign w_push    = w_take && (w_lane == C_LAST_LANE);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (frame_start) begin
                r_state <= ACTIVE;
            end else if (w_final) begin
                r_state <= IDLE;
            end

            if (w_restart) begin
                r_byte_idx <= w_take ? 3'd1 : 3'd0;
                r_byte_cnt <= w_take ? CNT_W'(1) : '0;
            end else if (w_final) begin
                r_byte_idx <= '0;
                r_byte_cnt <= '0;
            end else if (w_take) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else if (w_take) begin
            for (int i = 0; i < WORD_BYTES - 1; i++) begin
                if (w_lane == 3'(i)) begin
                    r_lanes[i*8 +: 8] <= pixel;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt   <= '0;
            r_resync_cnt <= '0;
        end else begin
            if (w_push && w_full && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_restart && w_active && (r_resync_cnt != 32'hFFFF_FFFF)) begin
                r_resync_cnt <= r_resync_cnt + 1'b1;
            end
        end
    end

    cam_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({w_final, pixel, r_lanes}),
        .i_pop   (out_ready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid  = !w_empty;
    assign out_last   = w_rdata[64];
    assign out_data   = w_rdata[63:0];
    assign drop_cnt   = r_drop_cnt;
    assign resync_cnt = r_resync_cnt;
    assign busy       = w_active;

endmodule

`default_nettype wire
